// File: rtl/wb_stage_reg_nch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_stage_reg_nch_if                                             |
// | Brief    : Bus bundle for the MEM->WB N-channel pipeline register.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface wb_stage_reg_nch_if #(
  parameter int NCH     = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [NCH-1:0]     in_we;
  logic [NCH*AW-1:0]  in_addr;
  logic [NCH*DW-1:0]  in_data;
  logic               out_valid;
  logic [NCH-1:0]     out_we;
  logic [NCH*AW-1:0]  out_addr;
  logic [NCH*DW-1:0]  out_data;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  // Upstream pipeline control side
  modport master (
    output stall, flush, in_valid, in_we, in_addr, in_data,
    input  out_valid, out_we, out_addr, out_data,
    input  stall_cnt, bubble_cnt, flush_cnt
  );

  // Pipeline register side
  modport slave (
    input  stall, flush, in_valid, in_we, in_addr, in_data,
    output out_valid, out_we, out_addr, out_data,
    output stall_cnt, bubble_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage_reg_nch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_stage_reg_nch                                                |
// | Brief    : MEM->WB register, NCH write channels, load/hold/bubble/flush.    |
// |            Optional stall/bubble/flush counters: define WBREG_PERF_CNT_EN. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module wb_stage_reg_nch #(
  parameter int NCH     = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int STALL_W = 6,
  parameter int STG     = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_reg_nch_if.slave bus
);

  logic              w_own_stall;
  logic              w_dn_stall;
  logic              w_clear;
  logic              w_bubble;
  logic              w_hold;
  logic              w_load;
  logic [NCH-1:0]    w_we_gated;

  logic              r_valid;
  logic [NCH-1:0]    r_we;
  logic [NCH*AW-1:0] r_addr;
  logic [NCH*DW-1:0] r_data;

  assign w_own_stall = bus.stall[STG];

  // The last stage in the stall vector has nobody downstream to hold it.
  generate
    if (STG + 1 < STALL_W) begin : g_dn_stall
      assign w_dn_stall = bus.stall[STG+1];
    end else begin : g_last_stage
      assign w_dn_stall = 1'b0;
    end
  endgenerate

  assign w_bubble = ~bus.flush &  w_own_stall & ~w_dn_stall;
  assign w_hold   = ~bus.flush &  w_own_stall &  w_dn_stall;
  assign w_load   = ~bus.flush & ~w_own_stall;
  assign w_clear  =  bus.flush | w_bubble;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_we
      assign w_we_gated[gi] = bus.in_we[gi] & bus.in_valid;
    end
  endgenerate

  // Flush and bubble wipe addr/data as well so nothing stale is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_clear) begin
      r_valid <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= bus.in_valid;
      r_we    <= w_we_gated;
      r_addr  <= bus.in_addr;
      r_data  <= bus.in_data;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_we    = r_we;
  assign bus.out_addr  = r_addr;
  assign bus.out_data  = r_data;

`ifdef WBREG_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != c_cnt_max))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble && (r_bubble_cnt != c_cnt_max))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (bus.flush && (r_flush_cnt != c_cnt_max))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.bubble_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_reg_nch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_stage_reg_nch                                             |
// | Brief    : Directed + random bench for wb_stage_reg_nch vs a rule model.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_wb_stage_reg_nch;

  localparam int NCH     = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int STALL_W = 6;
  localparam int STG     = 4;
  localparam int CNT_W   = 16;
`ifdef WBREG_PERF_CNT_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wb_stage_reg_nch_if #(.NCH(NCH), .AW(AW), .DW(DW), .STALL_W(STALL_W), .CNT_W(CNT_W)) bus ();

  wb_stage_reg_nch #(
    .NCH(NCH), .AW(AW), .DW(DW), .STALL_W(STALL_W), .STG(STG), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: one record per channel plus the stage valid bit
  logic              m_valid;
  logic              m_we   [NCH];
  logic [AW-1:0]     m_addr [NCH];
  logic [DW-1:0]     m_data [NCH];
  logic [CNT_W-1:0]  m_stall_cnt, m_bubble_cnt, m_flush_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_cnt_max) ? v : v + 1'b1;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_we[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    m_stall_cnt = '0; m_bubble_cnt = '0; m_flush_cnt = '0;
  endtask

  task automatic model_clock(input logic [STALL_W-1:0] st, input logic fl, input logic v,
                             input logic [NCH-1:0] we, input logic [NCH*AW-1:0] a,
                             input logic [NCH*DW-1:0] d);
    int   dn_idx;
    logic dn;
    dn_idx = STG + 1;
    dn     = (dn_idx < STALL_W) ? st[dn_idx] : 1'b0;
    if (fl) begin
      model_clear();
      m_flush_cnt = sat_inc(m_flush_cnt);
    end else if (st[STG] && !dn) begin
      model_clear();
      m_bubble_cnt = sat_inc(m_bubble_cnt);
    end else if (st[STG] && dn) begin
      m_stall_cnt = sat_inc(m_stall_cnt);
    end else begin
      m_valid = v;
      for (int i = 0; i < NCH; i++) begin
        m_we[i]   = we[i] && v;
        m_addr[i] = a[i*AW +: AW];
        m_data[i] = d[i*DW +: DW];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0]    e_we;
    logic [NCH*AW-1:0] e_addr;
    logic [NCH*DW-1:0] e_data;
    for (int i = 0; i < NCH; i++) begin
      e_we[i]            = m_we[i];
      e_addr[i*AW +: AW] = m_addr[i];
      e_data[i*DW +: DW] = m_data[i];
    end
    chk({tag, ".valid"},  128'(bus.out_valid),  128'(m_valid));
    chk({tag, ".we"},     128'(bus.out_we),     128'(e_we));
    chk({tag, ".addr"},   128'(bus.out_addr),   128'(e_addr));
    chk({tag, ".data"},   128'(bus.out_data),   128'(e_data));
    chk({tag, ".stallc"}, 128'(bus.stall_cnt),  c_perf ? 128'(m_stall_cnt)  : 128'(0));
    chk({tag, ".bubc"},   128'(bus.bubble_cnt), c_perf ? 128'(m_bubble_cnt) : 128'(0));
    chk({tag, ".flc"},    128'(bus.flush_cnt),  c_perf ? 128'(m_flush_cnt)  : 128'(0));
  endtask

  // Drive just after an edge, let one edge pass, update the model, sample 1ns later.
  task automatic step(input string tag, input logic [STALL_W-1:0] st, input logic fl,
                      input logic v, input logic [NCH-1:0] we,
                      input logic [NCH*AW-1:0] a, input logic [NCH*DW-1:0] d);
    bus.stall = st; bus.flush = fl; bus.in_valid = v;
    bus.in_we = we; bus.in_addr = a; bus.in_data = d;
    @(posedge clk);
    model_clock(st, fl, v, we, a, d);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  function automatic logic [NCH*AW-1:0] rnd_addr();
    logic [NCH*AW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_data();
    logic [NCH*DW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [STALL_W-1:0] st;
    logic [CNT_W-1:0]   stall_before;
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.stall = '0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_we = '0; bus.in_addr = '0; bus.in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Load ch0 {3, DEADBEEF} with both writes enabled
    step("load", 6'b000000, 1'b0, 1'b1, 2'b11, {5'd17, 5'd3}, {32'h1234_5678, 32'hDEAD_BEEF});
    chk("load.ch0data", 128'(bus.out_data[31:0]), 128'(32'hDEAD_BEEF));
    chk("load.ch0addr", 128'(bus.out_addr[4:0]), 128'(5'd3));

    // Hold three cycles while inputs churn
    for (int k = 0; k < 3; k++)
      step("hold", 6'b110000, 1'b0, 1'b1, 2'b11, rnd_addr(), rnd_data());
    chk("hold.ch0data", 128'(bus.out_data[31:0]), 128'(32'hDEAD_BEEF));
    chk("hold.stallc3", 128'(bus.stall_cnt), c_perf ? 128'(3) : 128'(0));

    // Bubble then a normal load
    step("bubble", 6'b010000, 1'b0, 1'b1, 2'b11, rnd_addr(), rnd_data());
    step("resume", 6'b000000, 1'b0, 1'b1, 2'b01, rnd_addr(), rnd_data());

    // Flush beats hold; stall counter untouched
    stall_before = m_stall_cnt;
    step("flush", 6'b110000, 1'b1, 1'b1, 2'b11, rnd_addr(), rnd_data());
    chk("flush.stallc", 128'(bus.stall_cnt), c_perf ? 128'(stall_before) : 128'(0));

    // Invalid instruction: enables masked, payload captured
    step("novalid", 6'b000000, 1'b0, 1'b0, 2'b11, {5'd9, 5'd22}, {32'hCAFE_F00D, 32'h0BAD_CAFE});

    // Last-stage illegal combo still loads
    step("illegal", 6'b100000, 1'b0, 1'b1, 2'b10, rnd_addr(), rnd_data());

    // Asynchronous reset while held
    step("preRst", 6'b000000, 1'b0, 1'b1, 2'b11, rnd_addr(), rnd_data());
    bus.stall = 6'b110000;
    async_reset("asyncRst");
    step("postRst", 6'b110000, 1'b0, 1'b1, 2'b11, rnd_addr(), rnd_data());

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      st = STALL_W'($urandom);
      if ($urandom_range(0, 2) == 0) st[STG] = 1'b0;
      step("rand", st, ($urandom_range(0, 7) == 0), 1'($urandom), NCH'($urandom),
           rnd_addr(), rnd_data());
      if ($urandom_range(0, 63) == 0) async_reset("randRst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
